// File: rtl/dmux_stream_pkg.sv
// Shared types for the registered stream demultiplexor.
// Occupancy states double as the occupancy output encoding.
package dmux_stream_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEL_W = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    function automatic int num_out(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/dmux_onehot.sv
// Combinational select-to-one-hot decoder with enable.
// Output is all zeros when disabled.
module dmux_onehot #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    en_i,
    output logic [(1<<SEL_W)-1:0]   onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/dmux_stream.sv
// Registered stream demux: one input stream steered to 2**SEL_W consumers
// through a two-entry (head + skid) buffer with a registered in_ready.
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [(1<<SEL_W)-1:0]   out_valid,
    input  logic [(1<<SEL_W)-1:0]   out_ready,
    output logic [1:0]              occupancy
);

    localparam int NUM_OUT = num_out(SEL_W);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   head_data_q, head_data_d;
    logic [SEL_W-1:0]   head_sel_q, head_sel_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
    logic               in_ready_q, in_ready_d;

    logic               head_valid;
    logic               in_fire;
    logic               out_fire;
    logic [NUM_OUT-1:0] valid_vec;

    assign head_valid = (state_q != EMPTY);
    assign in_fire    = in_valid & in_ready_q;
    assign out_fire   = |(valid_vec & out_ready);

    dmux_onehot #(
        .SEL_W (SEL_W)
    ) u_dec (
        .sel_i    (head_sel_q),
        .en_i     (head_valid),
        .onehot_o (valid_vec)
    );

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_sel_d  = head_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    head_data_d = in_data;
                    head_sel_d  = in_sel;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    skid_data_d = in_data;
                    skid_sel_d  = in_sel;
                    state_d     = TWO;
                end else if (in_fire && out_fire) begin
                    head_data_d = in_data;
                    head_sel_d  = in_sel;
                end else if (out_fire) begin
                    state_d     = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the drain path exists
                if (out_fire) begin
                    head_data_d = skid_data_q;
                    head_sel_d  = skid_sel_q;
                    state_d     = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_data_q <= '0;
            head_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_sel_q  <= head_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = head_data_q;
    assign out_valid = valid_vec;
    assign occupancy = state_q;

endmodule
